// File: rtl/jtag_debug_host_pkg.sv
// Shared types and constants for the virtual-JTAG debug host driver.
`timescale 1ns/1ps
package jtag_debug_host_pkg;

  // Virtual JTAG sequencing states of the host.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_UDR  = 3'd4,
    S_RSP  = 3'd5
  } host_state_e;

  // Default debug-slave geometry.
  localparam int DEF_DR_WIDTH = 38;
  localparam int DEF_IR_WIDTH = 2;

  // IR codes understood by the debug slave.
  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACE     = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

endpackage

// File: rtl/jtag_debug_host_tck_gen.sv
// Divided TCK generator with single-cycle rise/fall strobes.
// The strobes are high in the clk cycle before the edge where tck changes,
// so registers updated on a strobe switch together with tck.
`timescale 1ns/1ps
module jtag_debug_host_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic tck_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int CNT_W = $clog2(TCK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tck_q, tck_d;
  logic             run_q;
  logic             active;
  logic             wrap;

  // A delayed copy of run gives the first low phase one settling cycle
  // after the command is accepted.
  assign active     = run_i & run_q;
  assign wrap       = active & (cnt_q == CNT_LAST);
  assign rise_stb_o = wrap & ~tck_q;
  assign fall_stb_o = wrap & tck_q;
  assign tck_o      = tck_q;

  // Next-state for the half-period counter; tck is forced low when idle.
  always_comb begin
    cnt_d = '0;
    tck_d = 1'b0;
    if (active) begin
      tck_d = tck_q;
      if (wrap) begin
        cnt_d = '0;
        tck_d = ~tck_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      run_q <= run_i;
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/jtag_debug_host_driver.sv
// Host/hub side of the Nios II debug-slave virtual-JTAG port: runs one
// UIR/CDR/SDR/UDR sequence per command and returns IR readback and TDO word.
`timescale 1ns/1ps
module jtag_debug_host_driver
  import jtag_debug_host_pkg::*;
#(
  parameter int DR_WIDTH = DEF_DR_WIDTH,
  parameter int IR_WIDTH = DEF_IR_WIDTH,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [IR_WIDTH-1:0] cmd_ir_i,
  input  logic [DR_WIDTH-1:0] cmd_dr_i,
  input  logic                cmd_ir_only_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [IR_WIDTH-1:0] rsp_ir_out_o,
  output logic [DR_WIDTH-1:0] rsp_dr_o,
  output logic                vji_tck_o,
  output logic                vji_tdi_o,
  input  logic                vji_tdo_i,
  output logic [IR_WIDTH-1:0] vji_ir_in_o,
  input  logic [IR_WIDTH-1:0] vji_ir_out_i,
  output logic                vji_rti_o,
  output logic                vji_cdr_o,
  output logic                vji_sdr_o,
  output logic                vji_udr_o,
  output logic                vji_uir_o
);

  if (TCK_DIV < 2) begin : g_bad_tck_div
    $error("jtag_debug_host_driver: TCK_DIV must be at least 2");
  end

  localparam int BIT_W = $clog2(DR_WIDTH + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

  host_state_e         state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [IR_WIDTH-1:0] rsp_ir_out_q, rsp_ir_out_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                ir_only_q, ir_only_d;
  logic                tdi_q, tdi_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic                rti_q, rti_d;
  logic                cdr_q, cdr_d;
  logic                sdr_q, sdr_d;
  logic                udr_q, udr_d;
  logic                uir_q, uir_d;

  logic tck_run;
  logic rise_stb;
  logic fall_stb;

  assign tck_run = (state_q == S_UIR) || (state_q == S_CDR) ||
                   (state_q == S_SDR) || (state_q == S_UDR);

  jtag_debug_host_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .run_i      (tck_run),
    .tck_o      (vji_tck_o),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  // Virtual state sequencing: states advance on TCK falling strobes, data is
  // captured on rising strobes.
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_ir_out_d = rsp_ir_out_q;
    rsp_dr_d     = rsp_dr_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    ir_only_d    = ir_only_q;
    tdi_d        = tdi_q;
    ir_in_d      = ir_in_q;
    rti_d        = rti_q;
    cdr_d        = cdr_q;
    sdr_d        = sdr_q;
    udr_d        = udr_q;
    uir_d        = uir_q;
    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        rti_d       = 1'b1;
        if (cmd_valid_i && cmd_ready_q) begin
          state_d     = S_UIR;
          cmd_ready_d = 1'b0;
          rti_d       = 1'b0;
          ir_in_d     = cmd_ir_i;
          shift_d     = cmd_dr_i;
          ir_only_d   = cmd_ir_only_i;
          uir_d       = 1'b1;
        end
      end
      S_UIR: begin
        if (rise_stb) begin
          rsp_ir_out_d = vji_ir_out_i;
        end
        if (fall_stb) begin
          uir_d = 1'b0;
          if (ir_only_q) begin
            state_d     = S_RSP;
            rti_d       = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_dr_d    = '0;
          end else begin
            state_d = S_CDR;
            cdr_d   = 1'b1;
          end
        end
      end
      S_CDR: begin
        if (fall_stb) begin
          state_d   = S_SDR;
          cdr_d     = 1'b0;
          sdr_d     = 1'b1;
          tdi_d     = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      S_SDR: begin
        if (rise_stb) begin
          shift_d = {vji_tdo_i, shift_q[DR_WIDTH-1:1]};
        end
        if (fall_stb) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_UDR;
            sdr_d   = 1'b0;
            udr_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tdi_d     = shift_q[0];
          end
        end
      end
      S_UDR: begin
        if (fall_stb) begin
          state_d     = S_RSP;
          udr_d       = 1'b0;
          rti_d       = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_dr_d    = shift_q;
        end
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered output flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_ir_out_q <= '0;
      rsp_dr_q     <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      ir_only_q    <= 1'b0;
      tdi_q        <= 1'b0;
      ir_in_q      <= '0;
      rti_q        <= 1'b1;
      cdr_q        <= 1'b0;
      sdr_q        <= 1'b0;
      udr_q        <= 1'b0;
      uir_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_ir_out_q <= rsp_ir_out_d;
      rsp_dr_q     <= rsp_dr_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      ir_only_q    <= ir_only_d;
      tdi_q        <= tdi_d;
      ir_in_q      <= ir_in_d;
      rti_q        <= rti_d;
      cdr_q        <= cdr_d;
      sdr_q        <= sdr_d;
      udr_q        <= udr_d;
      uir_q        <= uir_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_ir_out_o = rsp_ir_out_q;
  assign rsp_dr_o     = rsp_dr_q;
  assign vji_tdi_o    = tdi_q;
  assign vji_ir_in_o  = ir_in_q;
  assign vji_rti_o    = rti_q;
  assign vji_cdr_o    = cdr_q;
  assign vji_sdr_o    = sdr_q;
  assign vji_udr_o    = udr_q;
  assign vji_uir_o    = uir_q;

endmodule

// File: tb/tb_jtag_debug_host_driver.sv
// Directed bench for jtag_debug_host_driver with a behavioural debug-slave
// shift register on each of two instances (TCK_DIV=4 and TCK_DIV=2).
`timescale 1ns/1ps
module tb_jtag_debug_host_driver;
  import jtag_debug_host_pkg::*;

  localparam logic [37:0] SLV_WORD_A = 38'h2A_5A5A_5A5A;
  localparam logic [37:0] CMD_WORD_A = 38'h15_1234_5678;
  localparam logic [37:0] SLV_WORD_B = 38'h03_CAFE_F00D;
  localparam logic [37:0] CMD_WORD_B = 38'h3C_0F0F_1357;
  localparam logic [37:0] SLV_WORD_C = 38'h11_8421_BEEF;
  localparam logic [37:0] CMD_WORD_C = 38'h2F_DEAD_0042;

  logic        clk;
  logic        rstN;

  logic        cmdValid, cmdReady, cmdIrOnly, rspValid, rspReady;
  logic [1:0]  cmdIr, rspIrOut, vjiIrIn, vjiIrOut;
  logic [37:0] cmdDr, rspDr;
  logic        vjiTck, vjiTdi, vjiTdo, vjiRti, vjiCdr, vjiSdr, vjiUdr, vjiUir;

  logic        cmdValid2, cmdReady2, rspValid2, rspReady2;
  logic [1:0]  rspIrOut2, vjiIrIn2;
  logic [37:0] rspDr2;
  logic        vjiTck2, vjiTdi2, vjiTdo2, vjiRti2, vjiCdr2, vjiSdr2, vjiUdr2, vjiUir2;

  logic [37:0] slvSr, slvLoadVal, slvSr2, slvLoadVal2;
  logic        slvLoad, slvLoad2;
  int          uirCnt, cdrCnt, sdrCnt, udrCnt, sdrCnt2;
  time         lastRise, tckPeriod, lastRise2, tckPeriod2;

  int compareCnt = 0;
  int mismatchCnt = 0;

  // 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  jtag_debug_host_driver #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(4)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_ir_i(cmdIr),
    .cmd_dr_i(cmdDr), .cmd_ir_only_i(cmdIrOnly),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_ir_out_o(rspIrOut),
    .rsp_dr_o(rspDr),
    .vji_tck_o(vjiTck), .vji_tdi_o(vjiTdi), .vji_tdo_i(vjiTdo),
    .vji_ir_in_o(vjiIrIn), .vji_ir_out_i(vjiIrOut),
    .vji_rti_o(vjiRti), .vji_cdr_o(vjiCdr), .vji_sdr_o(vjiSdr),
    .vji_udr_o(vjiUdr), .vji_uir_o(vjiUir)
  );

  jtag_debug_host_driver #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(2)) dut2 (
    .clk_i(clk), .rst_ni(rstN),
    .cmd_valid_i(cmdValid2), .cmd_ready_o(cmdReady2), .cmd_ir_i(IR_TRACE),
    .cmd_dr_i(CMD_WORD_A), .cmd_ir_only_i(1'b0),
    .rsp_valid_o(rspValid2), .rsp_ready_i(rspReady2), .rsp_ir_out_o(rspIrOut2),
    .rsp_dr_o(rspDr2),
    .vji_tck_o(vjiTck2), .vji_tdi_o(vjiTdi2), .vji_tdo_i(vjiTdo2),
    .vji_ir_in_o(vjiIrIn2), .vji_ir_out_i(2'b01),
    .vji_rti_o(vjiRti2), .vji_cdr_o(vjiCdr2), .vji_sdr_o(vjiSdr2),
    .vji_udr_o(vjiUdr2), .vji_uir_o(vjiUir2)
  );

  // Debug-slave model for the TCK_DIV=4 instance: DR shifts LSB-first on
  // rising TCK while sdr is high; also counts state pulses per command.
  assign vjiTdo = slvSr[0];
  always @(posedge vjiTck or posedge slvLoad) begin
    if (slvLoad) begin
      slvSr  <= slvLoadVal;
      uirCnt <= 0;
      cdrCnt <= 0;
      sdrCnt <= 0;
      udrCnt <= 0;
    end else begin
      if (vjiUir) uirCnt <= uirCnt + 1;
      if (vjiCdr) cdrCnt <= cdrCnt + 1;
      if (vjiUdr) udrCnt <= udrCnt + 1;
      if (vjiSdr) begin
        sdrCnt <= sdrCnt + 1;
        slvSr  <= {vjiTdi, slvSr[37:1]};
      end
      tckPeriod <= $time - lastRise;
      lastRise  <= $time;
    end
  end

  // Debug-slave model for the TCK_DIV=2 instance.
  assign vjiTdo2 = slvSr2[0];
  always @(posedge vjiTck2 or posedge slvLoad2) begin
    if (slvLoad2) begin
      slvSr2  <= slvLoadVal2;
      sdrCnt2 <= 0;
    end else begin
      if (vjiSdr2) begin
        sdrCnt2 <= sdrCnt2 + 1;
        slvSr2  <= {vjiTdi2, slvSr2[37:1]};
      end
      tckPeriod2 <= $time - lastRise2;
      lastRise2  <= $time;
    end
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCnt++;
    if (observed !== expected) begin
      mismatchCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic loadSlave(input logic [37:0] word);
    slvLoadVal = word;
    slvLoad = 1'b1;
    #1;
    slvLoad = 1'b0;
  endtask

  // Issue one command on the TCK_DIV=4 instance (called at a negedge) and
  // count clk edges from the accept edge until rsp_valid is seen.
  task automatic applyStimulus(input logic [1:0] ir, input logic [37:0] dr,
                               input logic irOnly, output int latency);
    int waitCnt;
    waitCnt = 0;
    latency = -1;
    while (!cmdReady && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!cmdReady) begin
      checkOutput("cmdReadyWait", 64'(cmdReady), 64'd1);
      return;
    end
    cmdIr = ir;
    cmdDr = dr;
    cmdIrOnly = irOnly;
    cmdValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
    latency = 0;
    while (!rspValid && latency < 1000) begin
      @(negedge clk);
      latency++;
    end
  endtask

  task automatic consumeRsp();
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("rspValidDrop", 64'(rspValid), 64'd0);
    checkOutput("cmdReadyBack", 64'(cmdReady), 64'd1);
  endtask

  initial begin
    int lat;
    int waitCnt;
    rstN = 1'b0;
    cmdValid = 1'b0; cmdIr = '0; cmdDr = '0; cmdIrOnly = 1'b0; rspReady = 1'b0;
    cmdValid2 = 1'b0; rspReady2 = 1'b0;
    vjiIrOut = IR_TRACECTRL;
    slvLoad = 1'b0; slvLoadVal = '0; slvLoad2 = 1'b0; slvLoadVal2 = '0;
    lastRise = 0; tckPeriod = 0; lastRise2 = 0; tckPeriod2 = 0;

    // Reset values while reset is held.
    repeat (5) @(negedge clk);
    checkOutput("rstRti", 64'(vjiRti), 64'd1);
    checkOutput("rstTck", 64'(vjiTck), 64'd0);
    checkOutput("rstCmdReady", 64'(cmdReady), 64'd0);
    checkOutput("rstRspValid", 64'(rspValid), 64'd0);
    checkOutput("rstVjiBus", 64'({vjiTdi, vjiIrIn, vjiCdr, vjiSdr, vjiUdr, vjiUir}), 64'd0);
    checkOutput("rstRspData", 64'({rspIrOut, rspDr}), 64'd0);
    rstN = 1'b1;
    checkOutput("cmdReadyBeforeEdge", 64'(cmdReady), 64'd0);
    @(negedge clk);
    checkOutput("cmdReadyAfterEdge", 64'(cmdReady), 64'd1);

    // Full scan with the reference words.
    loadSlave(SLV_WORD_A);
    applyStimulus(IR_TRACE, CMD_WORD_A, 1'b0, lat);
    checkOutput("fullLatency", 64'(lat), 64'd329);
    checkOutput("fullRspDr", 64'(rspDr), 64'(SLV_WORD_A));
    checkOutput("fullSlaveSr", 64'(slvSr), 64'(CMD_WORD_A));
    checkOutput("fullRspIr", 64'(rspIrOut), 64'(IR_TRACECTRL));
    checkOutput("fullUirCnt", 64'(uirCnt), 64'd1);
    checkOutput("fullCdrCnt", 64'(cdrCnt), 64'd1);
    checkOutput("fullSdrCnt", 64'(sdrCnt), 64'd38);
    checkOutput("fullUdrCnt", 64'(udrCnt), 64'd1);
    checkOutput("fullTckPeriod", 64'(tckPeriod), 64'd80);
    checkOutput("fullRspTck", 64'(vjiTck), 64'd0);
    checkOutput("fullRspRti", 64'(vjiRti), 64'd1);
    checkOutput("fullIrIn", 64'(vjiIrIn), 64'(IR_TRACE));

    // Backpressure: response held, a second command waits outside.
    loadSlave(SLV_WORD_B);
    cmdIr = IR_OCIMEM; cmdDr = CMD_WORD_B; cmdIrOnly = 1'b0; cmdValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bpRspValid", 64'(rspValid), 64'd1);
      checkOutput("bpRspDr", 64'(rspDr), 64'(SLV_WORD_A));
      checkOutput("bpCmdReady", 64'(cmdReady), 64'd0);
    end
    checkOutput("bpNoScan", 64'(uirCnt), 64'd0);
    consumeRsp();
    applyStimulus(IR_OCIMEM, CMD_WORD_B, 1'b0, lat);
    checkOutput("bpSecondLatency", 64'(lat), 64'd329);
    checkOutput("bpSecondRspDr", 64'(rspDr), 64'(SLV_WORD_B));
    checkOutput("bpSecondSlaveSr", 64'(slvSr), 64'(CMD_WORD_B));
    checkOutput("bpSecondIrIn", 64'(vjiIrIn), 64'(IR_OCIMEM));
    consumeRsp();

    // IR-only command.
    loadSlave(SLV_WORD_C);
    applyStimulus(IR_BREAK, CMD_WORD_C, 1'b1, lat);
    checkOutput("irOnlyLatency", 64'(lat), 64'd9);
    checkOutput("irOnlyRspIr", 64'(rspIrOut), 64'(2'b11));
    checkOutput("irOnlyRspDr", 64'(rspDr), 64'd0);
    checkOutput("irOnlyPulses", 64'({uirCnt[7:0], cdrCnt[7:0], sdrCnt[7:0], udrCnt[7:0]}),
                64'h01_00_00_00);
    checkOutput("irOnlySlaveSr", 64'(slvSr), 64'(SLV_WORD_C));
    consumeRsp();
    checkOutput("irInHeld", 64'(vjiIrIn), 64'(IR_BREAK));

    // Reset during SDR after ten bits.
    vjiIrOut = IR_OCIMEM;
    cmdIr = IR_TRACE; cmdDr = CMD_WORD_C; cmdIrOnly = 1'b0; cmdValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
    waitCnt = 0;
    while (sdrCnt < 10 && waitCnt < 1000) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("midSdrBits", 64'(sdrCnt), 64'd10);
    rstN = 1'b0;
    #1;
    checkOutput("midRstTck", 64'(vjiTck), 64'd0);
    checkOutput("midRstRti", 64'(vjiRti), 64'd1);
    checkOutput("midRstSdr", 64'(vjiSdr), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("midRstNoRsp", 64'(rspValid), 64'd0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("midRstCmdReady", 64'(cmdReady), 64'd1);
    loadSlave(SLV_WORD_C);
    applyStimulus(IR_TRACE, CMD_WORD_C, 1'b0, lat);
    checkOutput("postRstLatency", 64'(lat), 64'd329);
    checkOutput("postRstRspDr", 64'(rspDr), 64'(SLV_WORD_C));
    checkOutput("postRstSlaveSr", 64'(slvSr), 64'(CMD_WORD_C));
    checkOutput("postRstRspIr", 64'(rspIrOut), 64'(IR_OCIMEM));
    consumeRsp();

    // TCK_DIV=2 instance: same data, shorter TCK period and latency.
    slvLoadVal2 = SLV_WORD_A;
    slvLoad2 = 1'b1;
    #1;
    slvLoad2 = 1'b0;
    @(negedge clk);
    checkOutput("div2CmdReady", 64'(cmdReady2), 64'd1);
    cmdValid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmdValid2 = 1'b0;
    lat = 0;
    while (!rspValid2 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("div2Latency", 64'(lat), 64'd165);
    checkOutput("div2RspDr", 64'(rspDr2), 64'(SLV_WORD_A));
    checkOutput("div2SlaveSr", 64'(slvSr2), 64'(CMD_WORD_A));
    checkOutput("div2SdrCnt", 64'(sdrCnt2), 64'd38);
    checkOutput("div2TckPeriod", 64'(tckPeriod2), 64'd40);
    checkOutput("div2RspIr", 64'(rspIrOut2), 64'(2'b01));
    checkOutput("div2IrIn", 64'(vjiIrIn2), 64'(IR_TRACE));
    checkOutput("div2Idle", 64'({vjiTck2, vjiRti2, vjiCdr2, vjiUdr2, vjiUir2}), 64'b01000);
    rspReady2 = 1'b1;
    @(negedge clk);
    rspReady2 = 1'b0;
    checkOutput("div2RspDrop", 64'(rspValid2), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
    $finish;
  end

endmodule
